// File: rtl/plab5_mcore_proc_req_acc.sv
// Access-control stage on the processor->network request path: tags each request with the
// target security level of its address, forwards permitted requests, answers denied ones locally.
module plab5_mcore_proc_req_acc #(
    parameter int unsigned                p_opaque_nbits = 8,
    parameter int unsigned                p_addr_nbits   = 32,
    parameter int unsigned                p_data_nbits   = 32,
    parameter logic [p_addr_nbits-1:0]    p_hi_base      = 32'h0000_8000,
    parameter logic [p_addr_nbits-1:0]    p_hi_size      = 32'h0000_8000,
    localparam int unsigned               req_nbits      = 3 + p_opaque_nbits + p_addr_nbits + 2 + p_data_nbits,
    localparam int unsigned               resp_nbits     = 3 + p_opaque_nbits + 2 + p_data_nbits
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  proc_sec_level,
    input  logic                  proc_req_val,
    output logic                  proc_req_rdy,
    input  logic [req_nbits-1:0]  proc_req_msg,
    output logic                  net_req_val,
    input  logic                  net_req_rdy,
    output logic [req_nbits-1:0]  net_req_msg,
    output logic                  net_req_sec_level,
    output logic                  deny_resp_val,
    input  logic                  deny_resp_rdy,
    output logic [resp_nbits-1:0] deny_resp_msg,
    output logic [15:0]           deny_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FWD   = 2'd1,
        ST_DENY  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [req_nbits-1:0]    req_msg_q;
    logic                    sec_level_q;
    logic [resp_nbits-1:0]   deny_msg_q;
    logic [15:0]             deny_count_q;

    logic [2:0]              req_type;
    logic [p_opaque_nbits-1:0] req_opaque;
    logic [p_addr_nbits-1:0] req_addr;
    logic [1:0]              req_len;
    logic                    tgt_level;
    logic                    allowed;
    logic                    accept;

    assign req_type   = proc_req_msg[req_nbits-1 -: 3];
    assign req_opaque = proc_req_msg[p_addr_nbits + 2 + p_data_nbits +: p_opaque_nbits];
    assign req_addr   = proc_req_msg[2 + p_data_nbits +: p_addr_nbits];
    assign req_len    = proc_req_msg[p_data_nbits +: 2];

    // Offset form avoids the wrap that base+size would suffer near the top of the address space.
    assign tgt_level = (req_addr >= p_hi_base) && ((req_addr - p_hi_base) < p_hi_size);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        allowed = 1'b0;
        case (req_type)
            3'd0:    allowed = (tgt_level <= proc_sec_level);
            3'd1:    allowed = (tgt_level == proc_sec_level);
            default: allowed = 1'b0;
        endcase
    end

    assign accept = proc_req_val && proc_req_rdy;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = allowed ? ST_FWD : ST_DENY;
        end else begin
            case (state_q)
                ST_EMPTY: state_d = ST_EMPTY;
                ST_FWD:   if (net_req_rdy)   state_d = ST_EMPTY;
                ST_DENY:  if (deny_resp_rdy) state_d = ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Output logic: valids come from the state register only, ready may look at downstream.
    always_comb begin
        net_req_val   = 1'b0;
        deny_resp_val = 1'b0;
        proc_req_rdy  = 1'b0;
        case (state_q)
            ST_EMPTY: proc_req_rdy = 1'b1;
            ST_FWD: begin
                net_req_val  = 1'b1;
                proc_req_rdy = net_req_rdy;
            end
            ST_DENY: begin
                deny_resp_val = 1'b1;
                proc_req_rdy  = deny_resp_rdy;
            end
            default: proc_req_rdy = 1'b0;
        endcase
    end

    // Held entry and deny counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the held message registers are reset too, so nothing stale is ever visible.
            req_msg_q    <= '0;
            sec_level_q  <= 1'b0;
            deny_msg_q   <= '0;
            deny_count_q <= '0;
        end else if (accept) begin
            if (allowed) begin
                req_msg_q   <= proc_req_msg;
                sec_level_q <= tgt_level;
            end else begin
                deny_msg_q <= {req_type, req_opaque, req_len, {p_data_nbits{1'b0}}};
                if (deny_count_q != 16'hFFFF) begin
                    deny_count_q <= deny_count_q + 16'd1;
                end
            end
        end
    end

    assign net_req_msg       = req_msg_q;
    assign net_req_sec_level = sec_level_q;
    assign deny_resp_msg     = deny_msg_q;
    assign deny_count        = deny_count_q;

endmodule

// File: tb/tb_plab5_mcore_proc_req_acc.sv
// Scoreboard bench for plab5_mcore_proc_req_acc: a policy model predicts forwarded/denied
// traffic at accept time, a monitor checks whatever the DUT delivers.
module tb_plab5_mcore_proc_req_acc;

    localparam longint unsigned HI_BASE = 64'h0000_8000;
    localparam longint unsigned HI_SIZE = 64'h0000_8000;

    typedef struct {
        logic [76:0] msg;
        logic        lvl;
    } net_exp_t;

    logic        clk;
    logic        reset_n;
    logic        proc_sec_level;
    logic        proc_req_val;
    logic        proc_req_rdy;
    logic [76:0] proc_req_msg;
    logic        net_req_val;
    logic        net_req_rdy;
    logic [76:0] net_req_msg;
    logic        net_req_sec_level;
    logic        deny_resp_val;
    logic        deny_resp_rdy;
    logic [44:0] deny_resp_msg;
    logic [15:0] deny_count;

    net_exp_t    net_q[$];
    logic [44:0] deny_q[$];
    logic [15:0] exp_cnt;
    int          total;
    int          bad;

    plab5_mcore_proc_req_acc dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .proc_sec_level    (proc_sec_level),
        .proc_req_val      (proc_req_val),
        .proc_req_rdy      (proc_req_rdy),
        .proc_req_msg      (proc_req_msg),
        .net_req_val       (net_req_val),
        .net_req_rdy       (net_req_rdy),
        .net_req_msg       (net_req_msg),
        .net_req_sec_level (net_req_sec_level),
        .deny_resp_val     (deny_resp_val),
        .deny_resp_rdy     (deny_resp_rdy),
        .deny_resp_msg     (deny_resp_msg),
        .deny_count        (deny_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] o,
                                           input logic [31:0] a, input logic [1:0] l,
                                           input logic [31:0] d);
        return {t, o, a, l, d};
    endfunction

    // Reference policy: region membership by wide arithmetic, then the read/write rules.
    task automatic model_accept(input logic [76:0] m, input logic lvl);
        logic [2:0]      t;
        longint unsigned a;
        bit              tl;
        bit              ok;
        net_exp_t        e;
        t  = m[76:74];
        a  = longint'(m[65:34]);
        tl = (a >= HI_BASE) && (a < HI_BASE + HI_SIZE);
        if (t == 3'd0)      ok = (int'(tl) <= int'(lvl));
        else if (t == 3'd1) ok = (tl == lvl);
        else                ok = 1'b0;
        if (ok) begin
            e.msg = m;
            e.lvl = tl;
            net_q.push_back(e);
        end else begin
            deny_q.push_back({t, m[73:66], m[33:32], 32'd0});
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
    endtask

    // Monitor: every transfer the DUT completes is popped and compared.
    always @(negedge clk) begin
        if (reset_n) begin
            if (net_req_val && net_req_rdy) begin
                if (net_q.size() == 0) begin
                    check("net_unexpected_val", net_req_val, 1'b0);
                end else begin
                    net_exp_t e;
                    e = net_q.pop_front();
                    check("net_msg", net_req_msg, e.msg);
                    check("net_lvl", net_req_sec_level, e.lvl);
                end
            end
            if (deny_resp_val && deny_resp_rdy) begin
                if (deny_q.size() == 0) begin
                    check("deny_unexpected_val", deny_resp_val, 1'b0);
                end else begin
                    logic [44:0] d;
                    d = deny_q.pop_front();
                    check("deny_msg", deny_resp_msg, d);
                end
            end
        end
    end

    // One cycle: inputs were set #1 after the last edge; sample mid-cycle, then advance.
    task automatic step(output bit rdy_s);
        @(negedge clk);
        rdy_s = proc_req_rdy;
        check("deny_count", deny_count, exp_cnt);
        if (proc_req_val && rdy_s) model_accept(proc_req_msg, proc_sec_level);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [76:0] m, input logic l);
        bit r;
        int n;
        n = 0;
        proc_req_val   = 1'b1;
        proc_req_msg   = m;
        proc_sec_level = l;
        do begin
            step(r);
            n++;
        end while (!r && n < 50);
        check("send_accepted", r, 1'b1);
        proc_req_val = 1'b0;
    endtask

    task automatic drain();
        bit r;
        int n;
        n = 0;
        proc_req_val  = 1'b0;
        net_req_rdy   = 1'b1;
        deny_resp_rdy = 1'b1;
        while ((net_q.size() != 0 || deny_q.size() != 0) && n < 20) begin
            step(r);
            n++;
        end
        check("drain_net_left", net_q.size(), 0);
        check("drain_deny_left", deny_q.size(), 0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 32'h7FFF));
            1:       return 32'h8000 + 32'($urandom_range(0, 32'h7FFF));
            2:       return $urandom | 32'h0001_0000;
            default: begin
                case ($urandom_range(0, 5))
                    0:       return 32'h0000_7FFF;
                    1:       return 32'h0000_8000;
                    2:       return 32'h0000_FFFF;
                    3:       return 32'h0001_0000;
                    4:       return 32'hFFFF_FFFF;
                    default: return 32'h0000_0000;
                endcase
            end
        endcase
    endfunction

    initial begin
        bit          r;
        int          idx;
        logic [76:0] bp[4];
        logic [2:0]  t;
        int          k;

        total          = 0;
        bad            = 0;
        exp_cnt        = 16'd0;
        reset_n        = 1'b0;
        proc_sec_level = 1'b0;
        proc_req_val   = 1'b0;
        proc_req_msg   = '0;
        net_req_rdy    = 1'b1;
        deny_resp_rdy  = 1'b1;

        #3;
        check("rst_net_val", net_req_val, 1'b0);
        check("rst_deny_val", deny_resp_val, 1'b0);
        check("rst_count", deny_count, 16'd0);
        check("rst_net_msg", net_req_msg, 77'd0);
        check("rst_net_lvl", net_req_sec_level, 1'b0);
        check("rst_rdy", proc_req_rdy, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Allowed read into the high region
        send(mk_req(3'd0, 8'h11, 32'h0000_9000, 2'd0, 32'hDEAD_BEEF), 1'b1);
        check("rd_latency_val", net_req_val, 1'b1);
        check("rd_latency_lvl", net_req_sec_level, 1'b1);
        check("rd_latency_msg", net_req_msg, mk_req(3'd0, 8'h11, 32'h0000_9000, 2'd0, 32'hDEAD_BEEF));
        drain();

        // Denied write-down
        send(mk_req(3'd1, 8'h5A, 32'h0000_0100, 2'd2, 32'h1234_5678), 1'b1);
        check("wd_deny_val", deny_resp_val, 1'b1);
        check("wd_net_val", net_req_val, 1'b0);
        check("wd_deny_msg", deny_resp_msg, {3'd1, 8'h5A, 2'd2, 32'd0});
        check("wd_count", deny_count, 16'd1);
        drain();

        // Read-up denied, then the two region boundaries
        send(mk_req(3'd0, 8'h21, 32'h0000_FFFC, 2'd0, 32'd0), 1'b0);
        send(mk_req(3'd0, 8'h22, 32'h0000_7FFC, 2'd0, 32'd0), 1'b0);
        send(mk_req(3'd0, 8'h23, 32'h0001_0000, 2'd0, 32'd0), 1'b0);
        drain();

        // Backpressure: four back-to-back reads, net not ready for cycles 2-5
        for (int i = 0; i < 4; i++) bp[i] = mk_req(3'd0, 8'(8'h40 + i), 32'(32'h100 + 4 * i), 2'd0, 32'(i));
        idx = 0;
        for (int c = 1; c <= 12; c++) begin
            net_req_rdy    = !(c >= 2 && c <= 5);
            proc_req_val   = (idx < 4);
            proc_req_msg   = bp[idx % 4];
            proc_sec_level = 1'b0;
            step(r);
            if (c >= 2 && c <= 5) check("bp_rdy_stalled", r, 1'b0);
            if (proc_req_val && r) idx++;
        end
        check("bp_all_accepted", idx, 4);
        drain();

        // Level flip while an allowed high write is held
        net_req_rdy = 1'b0;
        send(mk_req(3'd1, 8'h77, 32'h0000_9ABC, 2'd1, 32'hCAFE_F00D), 1'b1);
        proc_sec_level = 1'b0;
        repeat (3) step(r);
        check("flip_held_val", net_req_val, 1'b1);
        check("flip_held_lvl", net_req_sec_level, 1'b1);
        drain();

        // Randomized traffic with random backpressure
        proc_req_val = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!proc_req_val || r) begin
                k = $urandom_range(0, 7);
                t = (k < 3) ? 3'd0 : (k < 6) ? 3'd1 : 3'($urandom_range(2, 7));
                proc_req_val   = ($urandom_range(0, 3) != 0);
                proc_req_msg   = mk_req(t, 8'($urandom), rand_addr(), 2'($urandom), $urandom);
                proc_sec_level = 1'($urandom);
            end
            net_req_rdy   = ($urandom_range(0, 3) != 0);
            deny_resp_rdy = ($urandom_range(0, 3) != 0);
            step(r);
            r = r && proc_req_val;
        end
        drain();

        // Saturation of the deny counter
        proc_req_val  = 1'b1;
        deny_resp_rdy = 1'b1;
        for (int c = 0; c < 65540; c++) begin
            proc_req_msg = mk_req(3'd2, 8'($urandom), $urandom, 2'd0, 32'd0);
            step(r);
        end
        proc_req_val = 1'b0;
        drain();
        check("sat_count", deny_count, 16'hFFFF);

        // Reset while FWD holds a request
        net_req_rdy = 1'b0;
        send(mk_req(3'd0, 8'h99, 32'h0000_0200, 2'd0, 32'h5555_AAAA), 1'b0);
        check("pre_rst_val", net_req_val, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_net_val", net_req_val, 1'b0);
        check("mid_rst_deny_val", deny_resp_val, 1'b0);
        check("mid_rst_count", deny_count, 16'd0);
        check("mid_rst_msg", net_req_msg, 77'd0);
        net_q.delete();
        deny_q.delete();
        exp_cnt = 16'd0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_rdy", proc_req_rdy, 1'b1);
        send(mk_req(3'd1, 8'h3C, 32'h0000_0300, 2'd3, 32'h0BAD_F00D), 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
